wb_retire: RTL and testbench

- Writeback/retire stage for the 4-slot bundle (A0, A1, M, LS).
- Accepts MEM-stage results and drives the regfile write ports consumed by ID: a0_wr/a0_tag/a0_en, a1_*, m_*, ls_*.
- Holds LS loads until the data memory returns read data, stalling upstream meanwhile.
- Resolves same-destination conflicts within a bundle and applies condition squash.

---
 rtl/wb_pkg.sv | 33 +++
 rtl/wb_retire_if.sv | 39 +++
 rtl/wb_conflict_resolve.sv | 26 ++
 rtl/wb_retire.sv | 165 ++++++++++++++++
 tb/tb_wb_retire.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the wb_retire writeback/retire stage.
package wb_pkg;

  localparam int DW    = 16;
  localparam int TW    = 5;
  localparam int NSLOT = 4;
  localparam int CNT_W = 8;

  // Slot indices double as the priority order: a higher index wins a tag conflict.
  localparam int SLOT_A0 = 0;
  localparam int SLOT_A1 = 1;
  localparam int SLOT_M  = 2;
  localparam int SLOT_LS = 3;

  typedef logic [DW-1:0]    data_t;
  typedef logic [TW-1:0]    tag_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    WAIT_LD = 1'b1
  } wb_state_e;

  function automatic logic [2:0] en_count(input logic [NSLOT-1:0] en);
    logic [2:0] sum;
    sum = '0;
    for (int i = 0; i < NSLOT; i++) begin
      sum = sum + {2'b00, en[i]};
    end
    return sum;
  endfunction

endpackage

// File: rtl/wb_retire_if.sv
// MEM-stage bundle, memory read return and regfile write ports of wb_retire.
interface wb_retire_if;
  import wb_pkg::*;

  logic  in_valid;
  logic  in_ready;
  logic  a0_v, a1_v, m_v, ls_v;
  logic  a0_sq, a1_sq, m_sq, ls_sq;
  data_t memA0_Rd, memA1_Rd, memM_Rd, memLS_Rd;
  tag_t  tmemA0_Rd, tmemA1_Rd, tmemM_Rd, tmemLS_Rd;
  logic  ls_is_load;
  logic  rd_valid;
  data_t rd_data;
  data_t a0_wr, a1_wr, m_wr, ls_wr;
  tag_t  a0_tag, a1_tag, m_tag, ls_tag;
  logic  a0_en, a1_en, m_en, ls_en;
  logic  stall;
  logic  wconflict;
  logic  ld_timeout;

  modport master (
    output in_valid, a0_v, a1_v, m_v, ls_v, a0_sq, a1_sq, m_sq, ls_sq,
           memA0_Rd, memA1_Rd, memM_Rd, memLS_Rd,
           tmemA0_Rd, tmemA1_Rd, tmemM_Rd, tmemLS_Rd,
           ls_is_load, rd_valid, rd_data,
    input  in_ready, a0_wr, a1_wr, m_wr, ls_wr, a0_tag, a1_tag, m_tag, ls_tag,
           a0_en, a1_en, m_en, ls_en, stall, wconflict, ld_timeout
  );

  modport slave (
    input  in_valid, a0_v, a1_v, m_v, ls_v, a0_sq, a1_sq, m_sq, ls_sq,
           memA0_Rd, memA1_Rd, memM_Rd, memLS_Rd,
           tmemA0_Rd, tmemA1_Rd, tmemM_Rd, tmemLS_Rd,
           ls_is_load, rd_valid, rd_data,
    output in_ready, a0_wr, a1_wr, m_wr, ls_wr, a0_tag, a1_tag, m_tag, ls_tag,
           a0_en, a1_en, m_en, ls_en, stall, wconflict, ld_timeout
  );

endinterface

// File: rtl/wb_conflict_resolve.sv
// Combinational same-tag resolution across the four slots; higher slot index wins.
module wb_conflict_resolve
  import wb_pkg::*;
(
  input  logic [NSLOT-1:0]         eff_i,
  input  logic [NSLOT-1:0][TW-1:0] tag_i,
  output logic [NSLOT-1:0]         keep_o,
  output logic                     conflict_o
);

  // A slot loses if any effective higher-priority slot targets the same tag,
  // whether or not that winner itself survives.
  always_comb begin
    keep_o     = eff_i;
    conflict_o = 1'b0;
    for (int lo = 0; lo < NSLOT; lo++) begin
      for (int hi = lo + 1; hi < NSLOT; hi++) begin
        if (eff_i[lo] && eff_i[hi] && (tag_i[lo] == tag_i[hi])) begin
          keep_o[lo] = 1'b0;
          conflict_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/wb_retire.sv
// Writeback/retire stage: resolves bundle write conflicts and holds LS loads for read data.
// Optional macro WB_RETIRE_CNT_EN adds cnt_clr input and retire_cnt write-enable counter.
module wb_retire
  import wb_pkg::*;
#(
  parameter int LD_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef WB_RETIRE_CNT_EN
  input  logic        cnt_clr,
  output logic [31:0] retire_cnt,
`endif
  wb_retire_if.slave  bus
);

  localparam cnt_t LD_LIMIT = cnt_t'(LD_TIMEOUT);

  wb_state_e state_q, state_d;
  cnt_t      cnt_q, cnt_d;
  tag_t      ld_tag_q, ld_tag_d;

  logic [NSLOT-1:0][DW-1:0] wr_q, wr_d;
  logic [NSLOT-1:0][TW-1:0] tag_q, tag_d;
  logic [NSLOT-1:0]         en_q, en_d;
  logic                     wconflict_q, wconflict_d;
  logic                     ld_timeout_q, ld_timeout_d;

  logic                     stall;
  logic                     accept;
  logic [NSLOT-1:0]         eff;
  logic [NSLOT-1:0]         keep;
  logic                     conflict;
  logic [NSLOT-1:0][DW-1:0] data_in;
  logic [NSLOT-1:0][TW-1:0] tag_in;

  assign stall  = (state_q == WAIT_LD);
  assign accept = bus.in_valid & ~stall;

  // Packing order follows the slot indices: {LS, M, A1, A0}.
  assign data_in = {bus.memLS_Rd, bus.memM_Rd, bus.memA1_Rd, bus.memA0_Rd};
  assign tag_in  = {bus.tmemLS_Rd, bus.tmemM_Rd, bus.tmemA1_Rd, bus.tmemA0_Rd};
  assign eff     = {accept & bus.ls_v & ~bus.ls_sq,
                    accept & bus.m_v  & ~bus.m_sq,
                    accept & bus.a1_v & ~bus.a1_sq,
                    accept & bus.a0_v & ~bus.a0_sq};

  wb_conflict_resolve u_resolve (
    .eff_i      (eff),
    .tag_i      (tag_in),
    .keep_o     (keep),
    .conflict_o (conflict)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ld_tag_d     = ld_tag_q;
    wr_d         = wr_q;
    tag_d        = tag_q;
    en_d         = '0;
    wconflict_d  = 1'b0;
    ld_timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          for (int s = SLOT_A0; s <= SLOT_M; s++) begin
            wr_d[s]  = data_in[s];
            tag_d[s] = tag_in[s];
            en_d[s]  = keep[s];
          end
          wconflict_d = conflict;
          if (keep[SLOT_LS]) begin
            if (bus.ls_is_load) begin
              state_d  = WAIT_LD;
              cnt_d    = '0;
              ld_tag_d = tag_in[SLOT_LS];
            end else begin
              wr_d[SLOT_LS]  = data_in[SLOT_LS];
              tag_d[SLOT_LS] = tag_in[SLOT_LS];
              en_d[SLOT_LS]  = 1'b1;
            end
          end
        end
      end
      WAIT_LD: begin
        // Read data on the final allowed cycle still counts as a successful load.
        if (bus.rd_valid) begin
          wr_d[SLOT_LS]  = bus.rd_data;
          tag_d[SLOT_LS] = ld_tag_q;
          en_d[SLOT_LS]  = 1'b1;
          state_d        = IDLE;
        end else if (cnt_q == LD_LIMIT) begin
          ld_timeout_d = 1'b1;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ld_tag_q     <= '0;
      wr_q         <= '0;
      tag_q        <= '0;
      en_q         <= '0;
      wconflict_q  <= 1'b0;
      ld_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ld_tag_q     <= ld_tag_d;
      wr_q         <= wr_d;
      tag_q        <= tag_d;
      en_q         <= en_d;
      wconflict_q  <= wconflict_d;
      ld_timeout_q <= ld_timeout_d;
    end
  end

  assign bus.in_ready   = ~stall;
  assign bus.stall      = stall;
  assign bus.wconflict  = wconflict_q;
  assign bus.ld_timeout = ld_timeout_q;
  assign bus.a0_wr      = wr_q[SLOT_A0];
  assign bus.a1_wr      = wr_q[SLOT_A1];
  assign bus.m_wr       = wr_q[SLOT_M];
  assign bus.ls_wr      = wr_q[SLOT_LS];
  assign bus.a0_tag     = tag_q[SLOT_A0];
  assign bus.a1_tag     = tag_q[SLOT_A1];
  assign bus.m_tag      = tag_q[SLOT_M];
  assign bus.ls_tag     = tag_q[SLOT_LS];
  assign bus.a0_en      = en_q[SLOT_A0];
  assign bus.a1_en      = en_q[SLOT_A1];
  assign bus.m_en       = en_q[SLOT_M];
  assign bus.ls_en      = en_q[SLOT_LS];

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt_q, retire_cnt_d;

  always_comb begin
    retire_cnt_d = retire_cnt_q + {29'd0, en_count(en_q)};
    if (cnt_clr) begin
      retire_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_wb_retire.sv
// Testbench for wb_retire: directed vector table, load/timeout/reset sequences,
// and randomized bundles checked against a slot-priority reference model.
module tb_wb_retire;

  localparam int LDT = 4;

  typedef struct {
    logic             in_valid;
    logic [3:0]       v;
    logic [3:0]       sq;
    logic [3:0][15:0] data;
    logic [3:0][4:0]  tag;
    logic             ls_is_load;
    logic             rd_valid;
    logic [15:0]      rd_data;
  } stim_t;

  typedef struct {
    logic [3:0]       en;
    logic [3:0][15:0] wr;
    logic [3:0][4:0]  tag;
    logic             wconflict;
    logic             ld_timeout;
    logic             stall;
  } resp_t;

  typedef struct {
    stim_t s;
    resp_t r;
  } vec_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   failures;

  wb_retire_if bus ();

`ifdef WB_RETIRE_CNT_EN
  logic        cnt_clr;
  logic [31:0] retire_cnt;
  initial cnt_clr = 1'b0;
`endif

  wb_retire #(.LD_TIMEOUT(LDT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef WB_RETIRE_CNT_EN
    .cnt_clr    (cnt_clr),
    .retire_cnt (retire_cnt),
`endif
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference model state: whether a load is outstanding, cycles spent waiting, its tag.
  logic       m_pend;
  int         m_waited;
  logic [4:0] m_ptag;

  function automatic stim_t idle_stim();
    stim_t s;
    s.in_valid   = 1'b0;
    s.v          = '0;
    s.sq         = '0;
    s.data       = '0;
    s.tag        = '0;
    s.ls_is_load = 1'b0;
    s.rd_valid   = 1'b0;
    s.rd_data    = '0;
    return s;
  endfunction

  function automatic resp_t quiet_resp();
    resp_t r;
    r.en         = '0;
    r.wr         = '0;
    r.tag        = '0;
    r.wconflict  = 1'b0;
    r.ld_timeout = 1'b0;
    r.stall      = 1'b0;
    return r;
  endfunction

  function automatic vec_t mk(input logic iv, input logic [3:0] v, input logic [3:0] sq,
                              input logic [3:0][4:0] tg, input logic [3:0][15:0] dt,
                              input logic [3:0] een, input logic ewc);
    vec_t x;
    x.s          = idle_stim();
    x.s.in_valid = iv;
    x.s.v        = v;
    x.s.sq       = sq;
    x.s.tag      = tg;
    x.s.data     = dt;
    x.r          = quiet_resp();
    x.r.en       = een;
    x.r.wr       = dt;
    x.r.tag      = tg;
    x.r.wconflict = ewc;
    return x;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    bus.in_valid   = s.in_valid;
    bus.a0_v       = s.v[0];
    bus.a1_v       = s.v[1];
    bus.m_v        = s.v[2];
    bus.ls_v       = s.v[3];
    bus.a0_sq      = s.sq[0];
    bus.a1_sq      = s.sq[1];
    bus.m_sq       = s.sq[2];
    bus.ls_sq      = s.sq[3];
    bus.memA0_Rd   = s.data[0];
    bus.memA1_Rd   = s.data[1];
    bus.memM_Rd    = s.data[2];
    bus.memLS_Rd   = s.data[3];
    bus.tmemA0_Rd  = s.tag[0];
    bus.tmemA1_Rd  = s.tag[1];
    bus.tmemM_Rd   = s.tag[2];
    bus.tmemLS_Rd  = s.tag[3];
    bus.ls_is_load = s.ls_is_load;
    bus.rd_valid   = s.rd_valid;
    bus.rd_data    = s.rd_data;
  endtask

  task automatic checkOutput(input string nm, input resp_t exp, input bit all_fields);
    logic [3:0]       act_en;
    logic [3:0][15:0] act_wr;
    logic [3:0][4:0]  act_tag;
    act_en  = {bus.ls_en, bus.m_en, bus.a1_en, bus.a0_en};
    act_wr  = {bus.ls_wr, bus.m_wr, bus.a1_wr, bus.a0_wr};
    act_tag = {bus.ls_tag, bus.m_tag, bus.a1_tag, bus.a0_tag};
    cmp({nm, ".en"}, 32'(act_en), 32'(exp.en));
    for (int i = 0; i < 4; i++) begin
      if (all_fields || exp.en[i]) begin
        cmp($sformatf("%s.wr%0d", nm, i), 32'(act_wr[i]), 32'(exp.wr[i]));
        cmp($sformatf("%s.tag%0d", nm, i), 32'(act_tag[i]), 32'(exp.tag[i]));
      end
    end
    cmp({nm, ".wconflict"}, 32'(bus.wconflict), 32'(exp.wconflict));
    cmp({nm, ".ld_timeout"}, 32'(bus.ld_timeout), 32'(exp.ld_timeout));
    cmp({nm, ".stall"}, 32'(bus.stall), 32'(exp.stall));
    cmp({nm, ".in_ready"}, 32'(bus.in_ready), 32'(!exp.stall));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs one clock after s is presented, judged by slot priority and load rules.
  task automatic model_step(input stim_t s, output resp_t r);
    logic [3:0] eff;
    bit         beaten;
    r = quiet_resp();
    if (!m_pend) begin
      eff = s.in_valid ? (s.v & ~s.sq) : 4'b0000;
      for (int i = 0; i < 4; i++) begin
        if (eff[i]) begin
          beaten = 0;
          for (int j = i + 1; j < 4; j++) begin
            if (eff[j] && s.tag[j] == s.tag[i]) beaten = 1;
          end
          if (beaten) begin
            r.wconflict = 1'b1;
          end else if (i < 3 || !s.ls_is_load) begin
            r.en[i]  = 1'b1;
            r.wr[i]  = s.data[i];
            r.tag[i] = s.tag[i];
          end
        end
      end
      if (eff[3] && s.ls_is_load) begin
        m_pend   = 1'b1;
        m_waited = 0;
        m_ptag   = s.tag[3];
      end
    end else if (s.rd_valid) begin
      r.en[3]  = 1'b1;
      r.wr[3]  = s.rd_data;
      r.tag[3] = m_ptag;
      m_pend   = 1'b0;
    end else if (m_waited == LDT) begin
      r.ld_timeout = 1'b1;
      m_pend       = 1'b0;
    end else begin
      m_waited++;
    end
    r.stall = m_pend;
  endtask

  vec_t  table_v [9];
  stim_t s;
  resp_t e;

  initial begin
    tests    = 0;
    failures = 0;
    m_pend   = 1'b0;
    m_waited = 0;
    m_ptag   = '0;

    //                  iv    v        sq       tags {LS,M,A1,A0}            data {LS,M,A1,A0}                                 en       wc
    table_v[0] = mk(1'b1, 4'b0101, 4'b0000, {5'd0, 5'd7, 5'd0, 5'd3},   {16'h0, 16'h00FF, 16'h0, 16'h1234},           4'b0101, 1'b0);
    table_v[1] = mk(1'b1, 4'b0111, 4'b0000, {5'd0, 5'd5, 5'd5, 5'd5},   {16'h0, 16'hAAAA, 16'h2222, 16'h1111},        4'b0100, 1'b1);
    table_v[2] = mk(1'b1, 4'b0010, 4'b0010, {5'd0, 5'd0, 5'd6, 5'd0},   {16'h0, 16'h0, 16'h3333, 16'h0},              4'b0000, 1'b0);
    table_v[3] = mk(1'b0, 4'b0000, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd0},   {16'h0, 16'h0, 16'h0, 16'h0},                 4'b0000, 1'b0);
    table_v[4] = mk(1'b1, 4'b1001, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd0},   {16'h5A5A, 16'h0, 16'h0, 16'h0001},           4'b1000, 1'b1);
    table_v[5] = mk(1'b0, 4'b1111, 4'b0000, {5'd1, 5'd2, 5'd3, 5'd4},   {16'h1, 16'h2, 16'h3, 16'h4},                 4'b0000, 1'b0);
    table_v[6] = mk(1'b1, 4'b1110, 4'b1000, {5'd31, 5'd30, 5'd31, 5'd0}, {16'h4444, 16'h8000, 16'hFFFF, 16'h0},       4'b0110, 1'b0);
    table_v[7] = mk(1'b1, 4'b1111, 4'b0000, {5'd4, 5'd3, 5'd2, 5'd1},   {16'hD004, 16'hC003, 16'hB002, 16'hA001},     4'b1111, 1'b0);
    table_v[8] = mk(1'b1, 4'b0011, 4'b0001, {5'd0, 5'd0, 5'd9, 5'd9},   {16'h0, 16'h0, 16'h0909, 16'h0808},           4'b0010, 1'b0);

    // Reset state
    rst_n = 1'b0;
    applyStimulus(idle_stim());
    #12;
    checkOutput("reset", quiet_resp(), 1'b1);
    rst_n = 1'b1;
    step();

    // Directed single-cycle vectors
    for (int k = 0; k < 9; k++) begin
      applyStimulus(table_v[k].s);
      step();
      checkOutput($sformatf("vec%0d", k), table_v[k].r, 1'b0);
    end
    applyStimulus(idle_stim());
    step();
    checkOutput("vec_idle", quiet_resp(), 1'b0);

    // Load with three empty wait cycles, then read data; a bundle offered during the wait is ignored
    s = idle_stim();
    s.in_valid = 1'b1; s.v = 4'b1001; s.ls_is_load = 1'b1;
    s.tag = {5'd9, 5'd0, 5'd0, 5'd2}; s.data = {16'h0, 16'h0, 16'h0, 16'h0BAD};
    applyStimulus(s);
    step();
    e = quiet_resp(); e.en = 4'b0001; e.wr[0] = 16'h0BAD; e.tag[0] = 5'd2; e.stall = 1'b1;
    checkOutput("load_acc", e, 1'b0);
    s = idle_stim();
    s.in_valid = 1'b1; s.v = 4'b0001; s.tag[0] = 5'd11; s.data[0] = 16'h1111;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(s);
      step();
      e = quiet_resp(); e.stall = 1'b1;
      checkOutput($sformatf("load_wait%0d", k), e, 1'b0);
    end
    s = idle_stim(); s.rd_valid = 1'b1; s.rd_data = 16'hBEEF;
    applyStimulus(s);
    step();
    e = quiet_resp(); e.en = 4'b1000; e.wr[3] = 16'hBEEF; e.tag[3] = 5'd9;
    checkOutput("load_done", e, 1'b0);

    // Timeout: no read data for LDT+1 wait cycles
    s = idle_stim(); s.in_valid = 1'b1; s.v = 4'b1000; s.ls_is_load = 1'b1; s.tag[3] = 5'd12;
    applyStimulus(s);
    step();
    applyStimulus(idle_stim());
    for (int k = 0; k <= LDT; k++) begin
      step();
      e = quiet_resp(); e.stall = (k < LDT);
      e.ld_timeout = (k == LDT);
      checkOutput($sformatf("tmo_wait%0d", k), e, 1'b0);
    end
    step();
    checkOutput("tmo_after", quiet_resp(), 1'b0);

    // Read data exactly on the last allowed wait cycle still writes
    s = idle_stim(); s.in_valid = 1'b1; s.v = 4'b1000; s.ls_is_load = 1'b1; s.tag[3] = 5'd13;
    applyStimulus(s);
    step();
    applyStimulus(idle_stim());
    for (int k = 0; k < LDT; k++) step();
    s = idle_stim(); s.rd_valid = 1'b1; s.rd_data = 16'h7777;
    applyStimulus(s);
    step();
    e = quiet_resp(); e.en = 4'b1000; e.wr[3] = 16'h7777; e.tag[3] = 5'd13;
    checkOutput("tmo_edge", e, 1'b0);

    // Asynchronous reset while waiting for a load
    s = idle_stim(); s.in_valid = 1'b1; s.v = 4'b1000; s.ls_is_load = 1'b1; s.tag[3] = 5'd9;
    applyStimulus(s);
    step();
    applyStimulus(idle_stim());
    step();
    cmp("rst_pre.stall", 32'(bus.stall), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid", quiet_resp(), 1'b1);
    #2;
    rst_n = 1'b1;
    s = idle_stim(); s.rd_valid = 1'b1; s.rd_data = 16'hDEAD;
    applyStimulus(s);
    step();
    checkOutput("rst_after", quiet_resp(), 1'b0);

    // Randomized bundles against the reference model
    m_pend = 1'b0;
    for (int k = 0; k < 600; k++) begin
      s = idle_stim();
      s.in_valid   = ($urandom_range(0, 3) != 0);
      s.v          = 4'($urandom_range(0, 15));
      s.sq         = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      s.ls_is_load = ($urandom_range(0, 1) == 0);
      s.rd_valid   = ($urandom_range(0, 3) == 0);
      s.rd_data    = 16'($urandom);
      for (int i = 0; i < 4; i++) begin
        s.data[i] = 16'($urandom);
        s.tag[i]  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
      end
      applyStimulus(s);
      model_step(s, e);
      step();
      checkOutput($sformatf("rnd%0d", k), e, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
